dual_port_tc_ram: RTL

Parametrised true-dual-port tightly-coupled on-chip RAM with two Avalon-MM slaves (s1, s2) on one clock domain, serving the PCP core and a second master sharing the same buffer. Unlike the fixed 32x8192 macro-wrapped memory, it has configurable width, depth and read latency, explicit `readdatavalid`, and defined mixed-port collision resolution. It also flags collisions and out-of-range accesses and counts collisions.

---
 rtl/dual_port_tc_ram.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dual_port_tc_ram.sv
// rtl/dual_port_tc_ram.sv - true-dual-port tightly-coupled RAM with two Avalon-MM slaves
// Byte-lane writes, s1-priority collision merge, stallable read pipelines, collision/range flags.
module dual_port_tc_ram #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 13,
  parameter int DEPTH        = 8192,
  parameter int READ_LATENCY = 1,
  parameter bit RDW_NEW_DATA = 1'b1,
  parameter     INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  input  logic                    reset_req,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   address2,
  input  logic [DATA_WIDTH/8-1:0] byteenable2,
  input  logic                    chipselect2,
  input  logic                    read2,
  input  logic                    write2,
  input  logic [DATA_WIDTH-1:0]   writedata2,
  input  logic                    clken2,
  input  logic                    reset_req2,
  output logic [DATA_WIDTH-1:0]   readdata2,
  output logic                    readdatavalid2,
  output logic                    collision,
  output logic [1:0]              oor_error,
  output logic [15:0]             collision_count
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            p_acc, p_wr, p_rd, p_inr, p_clken, p_rvalid;
  logic [IW-1:0]         idx1, idx2;
  logic                  same_addr;
  logic [DATA_WIDTH-1:0] old1, old2, new1, new2;
  logic [DATA_WIDTH-1:0] p_word [2];
  logic [DATA_WIDTH-1:0] p_rdata [2];
  logic                  collision_d, collision_q;
  logic [1:0]            oor_d, oor_q;
  logic [15:0]           count_d, count_q;

  always_comb begin
    p_clken   = {clken2, clken};
    p_acc[0]  = chipselect  & (read  | write)  & clken  & ~reset_req  & ~reset;
    p_acc[1]  = chipselect2 & (read2 | write2) & clken2 & ~reset_req2 & ~reset;
    p_wr      = p_acc & {write2, write};
    p_rd      = p_acc & ~{write2, write};
    p_inr[0]  = {1'b0, address}  < DEPTH_W;
    p_inr[1]  = {1'b0, address2} < DEPTH_W;
    idx1      = address[IW-1:0];
    idx2      = address2[IW-1:0];
    same_addr = address == address2;
    old1      = mem[idx1];
    old2      = mem[idx2];
    // A reader's view of the word after the other port's write lands
    new1      = old1;
    new2      = old2;
    for (int i = 0; i < NB; i++) begin
      if (byteenable2[i]) new1[8*i +: 8] = writedata2[8*i +: 8];
      if (byteenable[i])  new2[8*i +: 8] = writedata[8*i +: 8];
    end
    p_word[0] = '0;
    p_word[1] = '0;
    if (p_inr[0]) p_word[0] = (RDW_NEW_DATA && p_wr[1] && p_inr[1] && same_addr) ? new1 : old1;
    if (p_inr[1]) p_word[1] = (RDW_NEW_DATA && p_wr[0] && p_inr[0] && same_addr) ? new2 : old2;
    collision_d = p_acc[0] & p_acc[1] & p_inr[0] & p_inr[1] & same_addr & (p_wr[0] | p_wr[1]);
    oor_d       = p_acc & ~p_inr;
    count_d     = count_q;
    if (collision_d && count_q != 16'hFFFF) count_d = count_q + 16'd1;
  end

  // s2 lanes also enabled by a colliding s1 write are masked so s1 wins
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (p_wr[1] && p_inr[1] && byteenable2[i] &&
          !(p_wr[0] && p_inr[0] && same_addr && byteenable[i]))
        mem[idx2][8*i +: 8] <= writedata2[8*i +: 8];
      if (p_wr[0] && p_inr[0] && byteenable[i])
        mem[idx1][8*i +: 8] <= writedata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      collision_q <= 1'b0;
      oor_q       <= 2'b00;
      count_q     <= 16'd0;
    end else begin
      collision_q <= collision_d;
      oor_q       <= oor_d;
      count_q     <= count_d;
    end
  end

  generate
    for (genvar p = 0; p < 2; p++) begin : g_port
      logic [READ_LATENCY-1:0] vld_q;
      logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];
      logic [DATA_WIDTH-1:0]   hold_q;

      // Stages advance only on clken; a held result stays until clken returns
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q  <= '0;
          hold_q <= '0;
          for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
        end else begin
          if (p_clken[p]) begin
            vld_q[0] <= p_rd[p];
            dat_q[0] <= p_word[p];
            for (int i = 1; i < READ_LATENCY; i++) begin
              vld_q[i] <= vld_q[i-1];
              dat_q[i] <= dat_q[i-1];
            end
          end
          hold_q <= p_rdata[p];
        end
      end

      assign p_rvalid[p] = vld_q[READ_LATENCY-1] & p_clken[p];
      assign p_rdata[p]  = p_rvalid[p] ? dat_q[READ_LATENCY-1] : hold_q;
    end
  endgenerate

  assign readdata        = p_rdata[0];
  assign readdata2       = p_rdata[1];
  assign readdatavalid   = p_rvalid[0];
  assign readdatavalid2  = p_rvalid[1];
  assign collision       = collision_q;
  assign oor_error       = oor_q;
  assign collision_count = count_q;

endmodule
